// File: rtl/p2s_serializer.sv
// rtl/p2s_serializer.sv - parallel-to-serial framer: start, data, optional even parity, stop
module p2s_serializer #(
    parameter int DATA_W    = 8,
    parameter int BIT_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pdata,
    input  logic              pvalid,
    output logic              pready,
    output logic              sdata,
    output logic              busy
);

    localparam int CW  = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
    localparam int DVW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0]  BIT_LAST = CW'(DATA_W - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shifted;
    logic [CW-1:0]     bit_cnt;
    logic [DVW-1:0]    div_cnt;
    logic              parity_bit;
    logic              head_bit;
    logic              div_wrap;

    assign pready   = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign div_wrap = (div_cnt == DIV_LAST);

    // head_bit is always the next bit to put on the line; the register is
    // pre-shifted each time a bit is launched.
    always_comb begin
        head_bit      = 1'b0;
        shreg_shifted = shreg;
        if (MSB_FIRST != 0) begin
            head_bit      = shreg[DATA_W-1];
            shreg_shifted = shreg << 1;
        end else begin
            head_bit      = shreg[0];
            shreg_shifted = shreg >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sdata      <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    sdata   <= 1'b1;
                    if (pvalid) begin
                        shreg      <= pdata;
                        parity_bit <= ^pdata;
                        bit_cnt    <= '0;
                        sdata      <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                    if (div_wrap) begin
                        sdata <= head_bit;
                        shreg <= shreg_shifted;
                        state <= DATA;
                    end
                end
                DATA: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                    if (div_wrap) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                sdata <= parity_bit;
                                state <= PARITY;
                            end else begin
                                sdata <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sdata   <= head_bit;
                            shreg   <= shreg_shifted;
                        end
                    end
                end
                PARITY: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                    if (div_wrap) begin
                        sdata <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                    if (div_wrap) begin
                        sdata <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    sdata <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// tb/tb_p2s_serializer.sv - self-checking bench for p2s_serializer in three configurations
module tb_p2s_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pdata_a;
    logic [7:0] pdata_b;
    logic       pdata_c;
    logic [2:0] pvalid;
    wire  [2:0] pready;
    wire  [2:0] sdata;
    wire  [2:0] busy;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    int cfg_dw  [3] = '{8, 8, 1};
    int cfg_bd  [3] = '{4, 4, 1};
    int cfg_msb [3] = '{1, 0, 1};
    int cfg_par [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    p2s_serializer #(.DATA_W(8), .BIT_DIV(4), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst(rst), .pdata(pdata_a), .pvalid(pvalid[0]),
        .pready(pready[0]), .sdata(sdata[0]), .busy(busy[0])
    );

    p2s_serializer #(.DATA_W(8), .BIT_DIV(4), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst(rst), .pdata(pdata_b), .pvalid(pvalid[1]),
        .pready(pready[1]), .sdata(sdata[1]), .busy(busy[1])
    );

    p2s_serializer #(.DATA_W(1), .BIT_DIV(1), .MSB_FIRST(1), .PARITY_EN(1)) dut_c (
        .clk(clk), .rst(rst), .pdata(pdata_c), .pvalid(pvalid[2]),
        .pready(pready[2]), .sdata(sdata[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    // Reference frame: list of line levels, one entry per clock cycle.
    task automatic build(input int inst, input logic [7:0] w);
        int   dw, bd, ones;
        bit   b;
        bit   bits[$];
        dw   = cfg_dw[inst];
        bd   = cfg_bd[inst];
        ones = 0;
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            b = (cfg_msb[inst] != 0) ? w[dw-1-i] : w[i];
            ones += int'(b);
            bits.push_back(b);
        end
        if (cfg_par[inst] != 0) bits.push_back(bit'(ones % 2));
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[j])
            for (int r = 0; r < bd; r++) exp_q.push_back(bits[j]);
    endtask

    task automatic drive(input int inst, input logic [7:0] w, input logic v);
        case (inst)
            0:       pdata_a = w;
            1:       pdata_b = w;
            default: pdata_c = w[0];
        endcase
        pvalid[inst] = v;
    endtask

    // Entered just after a falling edge with the target idle; the next rising
    // edge accepts w. Leaves just after the falling edge of the idle cycle.
    task automatic run_frame(input int inst, input logic [7:0] w, input bit keep,
                             input logic [7:0] next_w, input bit poke);
        build(inst, w);
        drive(inst, w, 1'b1);
        chk($sformatf("pready_before i%0d", inst), pready[inst], 1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (keep) drive(inst, next_w, 1'b1);
                else      drive(inst, w, 1'b0);
            end
            if (poke && k == 12) drive(inst, 8'hFF, 1'b1);
            if (poke && k == 13) drive(inst, 8'hFF, 1'b0);
            chk($sformatf("sdata i%0d w%02h k%0d", inst, w, k), sdata[inst], exp_q[k]);
            chk($sformatf("busy i%0d k%0d", inst, k), busy[inst], 1'b1);
            chk($sformatf("pready_busy i%0d k%0d", inst, k), pready[inst], 1'b0);
        end
        @(negedge clk);
        chk($sformatf("idle_sdata i%0d", inst), sdata[inst], 1'b1);
        chk($sformatf("idle_busy i%0d", inst), busy[inst], 1'b0);
        chk($sformatf("idle_pready i%0d", inst), pready[inst], 1'b1);
    endtask

    initial begin
        logic [7:0] rw;
        int         ri;
        rst     = 1'b1;
        pvalid  = '0;
        pdata_a = '0;
        pdata_b = '0;
        pdata_c = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_sdata i%0d", i), sdata[i], 1'b1);
            chk($sformatf("rst_busy i%0d", i), busy[i], 1'b0);
            chk($sformatf("rst_pready i%0d", i), pready[i], 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("pready_after_release", pready[0], 1'b1);

        run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
        run_frame(1, 8'h01, 1'b0, 8'h00, 1'b0);
        run_frame(2, 8'h01, 1'b0, 8'h00, 1'b0);

        run_frame(0, 8'h00, 1'b1, 8'hFF, 1'b0);
        run_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0);

        run_frame(0, 8'h5A, 1'b0, 8'h00, 1'b1);

        build(0, 8'h3C);
        drive(0, 8'h3C, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) drive(0, 8'h3C, 1'b0);
            chk($sformatf("abort_sdata k%0d", k), sdata[0], exp_q[k]);
        end
        rst = 1'b1;
        #1;
        chk("abort_sdata", sdata[0], 1'b1);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_pready", pready[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_frame(0, 8'h81, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 15; n++) begin
            ri = $urandom_range(0, 2);
            rw = 8'($urandom);
            run_frame(ri, rw, 1'b0, 8'h00, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
